// File: rtl/pl_mem_lsu.sv
// pl_mem_lsu: memory-stage load/store unit.
// Drives a req/gnt/rvalid data bus and stalls the pipeline until the access finishes.
module pl_mem_lsu #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        FaultM
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [7:0]  cnt;
  logic [1:0]  a;
  logic        access;
  logic        is_st;
  logic        legal;
  logic        aligned;
  logic        valid;
  logic        st_idle;
  logic        st_req;
  logic        st_wait;
  logic        st_done;
  logic        timeout;
  logic        complete;
  logic        rd_cap;
  logic        to_ev;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ext;

  assign a      = ALUResultM[1:0];
  assign access = MemReadM | MemWriteM;
  assign is_st  = MemWriteM;

  assign st_idle = (state == IDLE);
  assign st_req  = (state == REQ);
  assign st_wait = (state == WAIT);
  assign st_done = (state == DONE);

  // legality of funct3 for the direction and alignment
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b0;
    case (funct3M)
      3'b000: begin
        legal   = 1'b1;
        aligned = 1'b1;
      end
      3'b001: begin
        legal   = 1'b1;
        aligned = ~a[0];
      end
      3'b010: begin
        legal   = 1'b1;
        aligned = (a == 2'b00);
      end
      3'b100: begin
        legal   = ~is_st;
        aligned = 1'b1;
      end
      3'b101: begin
        legal   = ~is_st;
        aligned = ~a[0];
      end
      default: begin
        legal   = 1'b0;
        aligned = 1'b0;
      end
    endcase
  end

  assign valid = access & legal & aligned;

  // byte enables and lane-replicated store data
  always_comb begin
    be    = 4'b1111;
    wdata = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        be    = 4'b0001 << a;
        wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << a;
        wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = WriteDataM;
      end
    endcase
  end

  // lane select and sign/zero extension of the read word
  always_comb begin
    rbyte = dmem_rdata[7:0];
    case (a)
      2'd0: rbyte = dmem_rdata[7:0];
      2'd1: rbyte = dmem_rdata[15:8];
      2'd2: rbyte = dmem_rdata[23:16];
      2'd3: rbyte = dmem_rdata[31:24];
      default: rbyte = dmem_rdata[7:0];
    endcase
    rhalf = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3M)
      3'b000:  ext = {{24{rbyte[7]}}, rbyte};
      3'b001:  ext = {{16{rhalf[15]}}, rhalf};
      3'b100:  ext = {24'd0, rbyte};
      3'b101:  ext = {16'd0, rhalf};
      default: ext = dmem_rdata;
    endcase
  end

  assign timeout  = (cnt == LAST);
  assign complete = (st_req & dmem_gnt & (is_st | dmem_rvalid))
                  | (st_wait & dmem_rvalid);
  assign rd_cap   = ~is_st & ((st_req & dmem_gnt & dmem_rvalid)
                  | (st_wait & dmem_rvalid));
  assign to_ev    = (st_req | st_wait) & ~complete & timeout;

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      st_idle: if (valid) state_nxt = REQ;
      st_req: begin
        if (complete || timeout) state_nxt = DONE;
        else if (dmem_gnt)       state_nxt = WAIT;
      end
      st_wait: if (complete || timeout) state_nxt = DONE;
      st_done: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // wait counter: cleared while idle, counts REQ/WAIT cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= 8'd0;
    else if (st_req | st_wait) cnt <= cnt + 8'd1;
    else                       cnt <= 8'd0;
  end

  // load result: captured on completion, zeroed on timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ReadDataM <= 32'd0;
    else if (rd_cap) ReadDataM <= ext;
    else if (to_ev)  ReadDataM <= 32'd0;
  end

  assign dmem_req   = st_req;
  assign dmem_we    = st_req & is_st;
  assign dmem_be    = st_req ? be : 4'b0000;
  assign dmem_addr  = {ALUResultM[31:2], 2'b00};
  assign dmem_wdata = wdata;

  assign StallM = rst_n & ((st_idle & valid) | st_req | st_wait);
  assign FaultM = rst_n & ((st_idle & access & ~valid) | to_ev);

endmodule
